// File: rtl/fp2int_seq.sv
// Iterative FP (double, or single when P=1) to signed 32/64-bit integer converter with valid/ready handshakes.
// Optional build macro FP2INT_UNSIGNED_EN adds the is_unsigned port and unsigned result ranges.
module fp2int_seq #(
    parameter int SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] op,
    input  logic        P,
    input  logic [2:0]  rm,
    input  logic        to_long,
`ifdef FP2INT_UNSIGNED_EN
    input  logic        is_unsigned,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [4:0]  Flags,
    output logic        Denorm
);

    typedef enum logic [2:0] {ST_IDLE, ST_UNPACK, ST_SHIFT, ST_ROUND, ST_DONE} state_t;

    localparam logic [6:0] STEP_W = 7'(SHIFT_STEP);

    state_t      state_r, state_nxt_s;
    logic [63:0] op_r, mag_r, result_r;
    logic        p_r, long_r, sign_r, nan_r, ovf_r, den_r, g_r, s_r;
    logic [2:0]  rm_r;
    logic [6:0]  rem_r;
    logic [4:0]  flags_r;
    logic        denorm_r, in_ready_r, out_valid_r, uns_s;

    logic [10:0]  exp_raw_s;
    logic [11:0]  e_s;
    logic         frac_nz_s, exp_max_s, is_zero_s, is_ovf_s, sign_s;
    logic [6:0]   shamt_s, step_s, rem_nxt_s;
    logic [63:0]  mant_s;
    logic [127:0] wide_s;
    logic         inc_s, inv_s, inx_s;
    logic [64:0]  rnd_s, lim_s, ulim_s;
    logic [63:0]  max_s, min_s, val_s, res_s;

`ifdef FP2INT_UNSIGNED_EN
    logic uns_r;
    assign uns_s = uns_r;
`else
    assign uns_s = 1'b0;
`endif

    // Field extraction; single-precision exponents are rebiased onto the double scale.
    always_comb begin
        exp_raw_s = P ? 11'h000 : 11'h000;
        exp_raw_s = p_r ? {3'b000, op_r[30:23]} : op_r[62:52];
        frac_nz_s = p_r ? (|op_r[22:0]) : (|op_r[51:0]);
        exp_max_s = p_r ? (op_r[30:23] == 8'hFF) : (op_r[62:52] == 11'h7FF);
        e_s       = p_r ? (12'(op_r[30:23]) + 12'd896) : {1'b0, op_r[62:52]};
        sign_s    = p_r ? op_r[31] : op_r[63];
        mant_s    = p_r ? {1'b1, op_r[22:0], 40'd0} : {1'b1, op_r[51:0], 11'd0};
        is_zero_s = (exp_raw_s == 11'd0);
        is_ovf_s  = (e_s >= 12'd1087);
        shamt_s   = (e_s <= 12'd1021) ? 7'd65 : 7'(12'd1086 - e_s);
    end

    // One shifter step: the last bit out becomes G, everything below it folds into S.
    always_comb begin
        step_s    = (rem_r > STEP_W) ? STEP_W : rem_r;
        wide_s    = {mag_r, 64'd0} >> step_s;
        rem_nxt_s = rem_r - step_s;
    end

    // Rounding increment, range check and saturation of the final integer.
    always_comb begin
        case (rm_r)
            3'b001:  inc_s = 1'b0;
            3'b010:  inc_s = sign_r & (g_r | s_r);
            3'b011:  inc_s = ~sign_r & (g_r | s_r);
            3'b100:  inc_s = g_r;
            default: inc_s = g_r & (s_r | mag_r[0]);
        endcase
        rnd_s  = {1'b0, mag_r} + 65'(inc_s);
        lim_s  = long_r ? 65'h0_7FFF_FFFF_FFFF_FFFF : 65'h0_0000_0000_7FFF_FFFF;
        ulim_s = long_r ? 65'h0_FFFF_FFFF_FFFF_FFFF : 65'h0_0000_0000_FFFF_FFFF;
        max_s  = long_r ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
        min_s  = long_r ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
        val_s  = sign_r ? (64'd0 - rnd_s[63:0]) : rnd_s[63:0];
        inv_s  = 1'b1;
        inx_s  = 1'b0;
        res_s  = 64'd0;
        if (uns_s) begin
            if (nan_r) begin
                res_s = 64'hFFFF_FFFF_FFFF_FFFF;
            end else if (sign_r) begin
                inv_s = ovf_r | (rnd_s != 65'd0);
                inx_s = ~inv_s & (g_r | s_r);
            end else if (ovf_r || (rnd_s > ulim_s)) begin
                res_s = 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
                inv_s = 1'b0;
                inx_s = g_r | s_r;
                res_s = long_r ? rnd_s[63:0] : {{32{rnd_s[31]}}, rnd_s[31:0]};
            end
        end else begin
            if (nan_r) begin
                res_s = max_s;
            end else if (ovf_r || (rnd_s > (lim_s + 65'(sign_r)))) begin
                res_s = sign_r ? min_s : max_s;
            end else begin
                inv_s = 1'b0;
                inx_s = g_r | s_r;
                res_s = long_r ? val_s : {{32{val_s[31]}}, val_s[31:0]};
            end
        end
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_nxt_s = ST_UNPACK;
                else          state_nxt_s = ST_IDLE;
            end
            ST_UNPACK: begin
                if (is_zero_s || is_ovf_s || (shamt_s == 7'd0)) state_nxt_s = ST_ROUND;
                else                                             state_nxt_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (rem_nxt_s == 7'd0) state_nxt_s = ST_ROUND;
                else                   state_nxt_s = ST_SHIFT;
            end
            ST_ROUND: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        if (flush) state_nxt_s = ST_IDLE;
        else       state_nxt_s = state_nxt_s;
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand capture, unpack/shift datapath and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r <= 64'd0; p_r <= 1'b0; rm_r <= 3'd0; long_r <= 1'b0;
            mag_r <= 64'd0; g_r <= 1'b0; s_r <= 1'b0; rem_r <= 7'd0;
            sign_r <= 1'b0; nan_r <= 1'b0; ovf_r <= 1'b0; den_r <= 1'b0;
            result_r <= 64'd0; flags_r <= 5'd0; denorm_r <= 1'b0;
`ifdef FP2INT_UNSIGNED_EN
            uns_r <= 1'b0;
`endif
        end else if (state_r == ST_IDLE && in_valid) begin
            op_r <= op; p_r <= P; rm_r <= rm; long_r <= to_long;
`ifdef FP2INT_UNSIGNED_EN
            uns_r <= is_unsigned;
`endif
        end else if (state_r == ST_UNPACK) begin
            sign_r <= sign_s;
            nan_r  <= exp_max_s & frac_nz_s;
            ovf_r  <= is_ovf_s & ~is_zero_s;
            den_r  <= is_zero_s & frac_nz_s;
            mag_r  <= (is_zero_s || is_ovf_s) ? 64'd0 : mant_s;
            g_r    <= 1'b0;
            s_r    <= 1'b0;
            rem_r  <= shamt_s;
        end else if (state_r == ST_SHIFT) begin
            mag_r <= wide_s[127:64];
            g_r   <= wide_s[63];
            s_r   <= s_r | g_r | (|wide_s[62:0]);
            rem_r <= rem_nxt_s;
        end else if (state_r == ST_ROUND && !flush) begin
            result_r <= res_s;
            flags_r  <= {inv_s, 3'b000, inx_s};
            denorm_r <= den_r;
        end else begin
            mag_r <= mag_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign Flags     = flags_r;
    assign Denorm    = denorm_r;

endmodule

// File: tb/tb_fp2int_seq.sv
// Self-checking bench for fp2int_seq: directed vector table, handshake/flush/reset sequences,
// and randomized operands checked against an arithmetic reference model.
module tb_fp2int_seq;

    localparam int STEP = 8;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, p, to_long, out_valid, out_ready, denorm;
    logic [63:0] op, result;
    logic [2:0]  rm;
    logic [4:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    fp2int_seq #(.SHIFT_STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .P(p), .rm(rm), .to_long(to_long),
`ifdef FP2INT_UNSIGNED_EN
        .is_unsigned(1'b0),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .Flags(flags), .Denorm(denorm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] op;
        logic        p;
        logic [2:0]  rm;
        logic        lng;
        logic [63:0] res;
        logic [4:0]  flg;
        logic        den;
        int          lat;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: value = M * 2^E evaluated with wide integer arithmetic.
    function automatic void model(input logic [63:0] o, input logic pp, input logic [2:0] r_m,
                                  input logic lng, output logic [63:0] res, output logic [4:0] flg,
                                  output logic den, output int lat);
        logic         sgn, up, huge;
        int           ex, emax, bias, mb, edp, sh, e, k;
        logic [127:0] fr, m, q, r, half, maxp, qr;
        logic [63:0]  maxv, minv, v;
        if (pp) begin
            sgn = o[31]; ex = int'(o[30:23]); fr = 128'(o[22:0]); emax = 255; bias = 127; mb = 23;
        end else begin
            sgn = o[63]; ex = int'(o[62:52]); fr = 128'(o[51:0]); emax = 2047; bias = 1023; mb = 52;
        end
        edp = pp ? ex + 896 : ex;
        if (ex == 0 || edp >= 1087) lat = 2;
        else begin
            sh = 1086 - edp;
            if (sh > 65) sh = 65;
            lat = 2 + (sh + STEP - 1) / STEP;
        end
        maxv = lng ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
        minv = lng ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
        maxp = 128'(maxv);
        den = 1'b0; flg = 5'd0; res = 64'd0;
        if (ex == emax) begin
            res = (fr != 0 || !sgn) ? maxv : minv;
            flg = 5'b10000;
            return;
        end
        if (ex == 0) begin
            den = (fr != 0);
            return;
        end
        m = (128'd1 << mb) | fr;
        e = ex - bias - mb;
        huge = 1'b0; r = 128'd0; half = 128'd1; q = 128'd0;
        if (e >= 0) begin
            if (e > 70) huge = 1'b1;
            else        q = m << e;
        end else begin
            k = -e;
            if (k >= 100) begin
                r = m; half = 128'd1 << 99;
            end else begin
                q = m >> k; r = m - (q << k); half = 128'd1 << (k - 1);
            end
        end
        case (r_m)
            3'd1:    up = 1'b0;
            3'd2:    up = sgn && (r != 0);
            3'd3:    up = !sgn && (r != 0);
            3'd4:    up = (r != 0) && (r >= half);
            default: up = (r > half) || ((r == half) && (r != 0) && q[0]);
        endcase
        qr = q + 128'(up);
        if (huge || qr > maxp + 128'(sgn)) begin
            res = sgn ? minv : maxv;
            flg = 5'b10000;
        end else begin
            v = sgn ? -qr[63:0] : qr[63:0];
            res = lng ? v : {{32{v[31]}}, v[31:0]};
            flg = {4'b0000, r != 0};
        end
    endfunction

    task automatic start_op(input logic [63:0] o, input logic pp, input logic [2:0] r_m, input logic lng);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        op = o; p = pp; rm = r_m; to_long = lng; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = {$urandom, $urandom};
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
    endtask

    task automatic run_vec(input logic [63:0] o, input logic pp, input logic [2:0] r_m, input logic lng,
                           input logic [63:0] res, input logic [4:0] flg, input logic den,
                           input int lat, input int id);
        int c;
        start_op(o, pp, r_m, lng);
        wait_out(c);
        chk($sformatf("v%0d_latency", id), 64'(c), 64'(lat));
        if (out_valid) begin
            chk($sformatf("v%0d_result", id), result, res);
            chk($sformatf("v%0d_flags", id), 64'(flags), 64'(flg));
            chk($sformatf("v%0d_denorm", id), 64'(denorm), 64'(den));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d_valid_drop", id), 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] mres, o;
        logic [4:0]  mflg;
        logic        mden, pp, sg, lng;
        logic [2:0]  r_m;
        logic [51:0] fr;
        int          mlat, c, mode, ex;
        logic        seen;

        vt[0]  = '{64'h400C000000000000, 1'b0, 3'd0, 1'b1, 64'd4,                  5'b00001, 1'b0, 10};
        vt[1]  = '{64'hC004000000000000, 1'b0, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFE,   5'b00001, 1'b0, 10};
        vt[2]  = '{64'hC004000000000000, 1'b0, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFD,   5'b00001, 1'b0, 10};
        vt[3]  = '{64'h7FF8000000000000, 1'b0, 3'd0, 1'b1, 64'h7FFFFFFFFFFFFFFF,   5'b10000, 1'b0, 2};
        vt[4]  = '{64'h41E0000000000000, 1'b0, 3'd0, 1'b0, 64'h000000007FFFFFFF,   5'b10000, 1'b0, 6};
        vt[5]  = '{64'hC1E0000000000000, 1'b0, 3'd0, 1'b0, 64'hFFFFFFFF80000000,   5'b00000, 1'b0, 6};
        vt[6]  = '{64'h000000003F000000, 1'b1, 3'd0, 1'b1, 64'd0,                  5'b00001, 1'b0, 10};
        vt[7]  = '{64'h000000003F000000, 1'b1, 3'd3, 1'b1, 64'd1,                  5'b00001, 1'b0, 10};
        vt[8]  = '{64'h0000000000000001, 1'b1, 3'd0, 1'b1, 64'd0,                  5'b00000, 1'b1, 2};
        vt[9]  = '{64'hC3E0000000000000, 1'b0, 3'd0, 1'b1, 64'h8000000000000000,   5'b00000, 1'b0, 2};
        vt[10] = '{64'h43E0000000000000, 1'b0, 3'd0, 1'b1, 64'h7FFFFFFFFFFFFFFF,   5'b10000, 1'b0, 2};
        vt[11] = '{64'hFFF0000000000000, 1'b0, 3'd0, 1'b0, 64'hFFFFFFFF80000000,   5'b10000, 1'b0, 2};
        vt[12] = '{64'h3FE0000000000000, 1'b0, 3'd4, 1'b1, 64'd1,                  5'b00001, 1'b0, 10};
        vt[13] = '{64'h3FD0000000000000, 1'b0, 3'd3, 1'b1, 64'd1,                  5'b00001, 1'b0, 11};
        vt[14] = '{64'hBF20000000000000, 1'b0, 3'd2, 1'b1, 64'hFFFFFFFFFFFFFFFF,   5'b00001, 1'b0, 11};
        vt[15] = '{64'h0000000000000000, 1'b0, 3'd0, 1'b0, 64'd0,                  5'b00000, 1'b0, 2};

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 64'd0; p = 1'b0; rm = 3'd0; to_long = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_denorm", 64'(denorm), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            run_vec(vt[i].op, vt[i].p, vt[i].rm, vt[i].lng, vt[i].res, vt[i].flg, vt[i].den, vt[i].lat, i);

        // Back-pressure: outputs hold while out_ready stays low.
        start_op(64'h400C000000000000, 1'b0, 3'd0, 1'b1);
        wait_out(c);
        chk("bp_latency", 64'(c), 64'd10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_result", result, 64'd4);
            chk("bp_flags", 64'(flags), 64'd1);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        run_vec(64'h3FF0000000000000, 1'b0, 3'd0, 1'b1, 64'd1, 5'b00000, 1'b0, 10, 100);

        // Flush mid-shift: back to idle, no result pulse, outputs unchanged.
        start_op(64'h400C000000000000, 1'b0, 3'd1, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen = seen | out_valid;
            @(posedge clk); #1;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        chk("flush_result_kept", result, 64'd1);
        run_vec(64'h400C000000000000, 1'b0, 3'd1, 1'b1, 64'd3, 5'b00001, 1'b0, 10, 101);

        // Asynchronous reset mid-shift.
        start_op(64'h400C000000000000, 1'b0, 3'd0, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        #2;
        reset_n = 1'b0;
        #1;
        chk("amid_rst_valid", 64'(out_valid), 64'd0);
        chk("amid_rst_result", result, 64'd0);
        chk("amid_rst_flags", 64'(flags), 64'd0);
        chk("amid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_vec(64'hC004000000000000, 1'b0, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFE, 5'b00001, 1'b0, 10, 102);

        // Randomized operands against the reference model.
        for (int i = 0; i < 400; i++) begin
            pp   = 1'($urandom_range(0, 1));
            lng  = 1'($urandom_range(0, 1));
            r_m  = 3'($urandom_range(0, 7));
            sg   = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 9);
            fr   = {20'($urandom), $urandom};
            if ($urandom_range(0, 2) == 0) fr = fr & ({52{1'b1}} << $urandom_range(0, 52));
            o = {$urandom, $urandom};
            if (mode == 0) begin
                o = o;
            end else if (mode == 1) begin
                ex = ($urandom_range(0, 1) == 0) ? 0 : 2047;
                if ($urandom_range(0, 1) == 0) fr = 52'd0;
                if (pp) o[31:0] = {sg, (ex == 0) ? 8'h00 : 8'hFF, fr[51:29]};
                else    o = {sg, 11'(ex), fr};
            end else begin
                if (pp) begin
                    ex = 124 + $urandom_range(0, 67);
                    o[31:0] = {sg, 8'(ex), fr[51:29]};
                end else begin
                    ex = 1020 + $urandom_range(0, 67);
                    o = {sg, 11'(ex), fr};
                end
            end
            model(o, pp, r_m, lng, mres, mflg, mden, mlat);
            run_vec(o, pp, r_m, lng, mres, mflg, mden, mlat, 1000 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
